// File: rtl/f_btb_lookup_pkg.sv
// ============================================================================
// Module : f_btb_lookup_pkg
// Brief  : Shared BTB geometry and entry field offsets (fetch and execute).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package f_btb_lookup_pkg;
  localparam int PC_W      = 13;
  localparam int IDX_W     = 11;
  localparam int TAG_W     = PC_W - IDX_W;
  localparam int ENT_W     = 1 + TAG_W + PC_W;
  localparam int NUM_ENT   = 1 << IDX_W;
  // Entry layout: {valid, tag, target}
  localparam int VALID_BIT = ENT_W - 1;
  localparam int TAG_LSB   = PC_W;
  localparam int TGT_LSB   = 0;
endpackage

`default_nettype wire

// File: rtl/f_btb_lookup_btb_ram.sv
// ============================================================================
// Module : f_btb_lookup_btb_ram
// Brief  : 1R1W synchronous-read array with write-first bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module f_btb_lookup_btb_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/f_btb_lookup.sv
// ============================================================================
// Module : f_btb_lookup
// Brief  : Fetch-stage BTB lookup with post-reset valid-clear sweep.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module f_btb_lookup
  import f_btb_lookup_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  r_pc,
  input  logic [ENT_W-1:0] w_data,
  input  logic [IDX_W-1:0] w_addr,
  input  logic             wen,
  output logic [PC_W-1:0]  pc_predicted,
  output logic             hit,
  output logic             ready
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] clr_addr_q, clr_addr_d;
  logic             ready_q, ready_d;
  logic             run_q;
  logic [TAG_W-1:0] tag_q;
  logic [PC_W-1:0]  pc_inc_q;

  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [ENT_W-1:0] ram_wdata;
  logic [ENT_W-1:0] ram_rdata;

  // The sweep owns the write port; external writes are dropped until RUN.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ready_d    = ready_q;
    ram_we     = wen;
    ram_waddr  = w_addr;
    ram_wdata  = w_data;
    if (state_q == S_CLEAR) begin
      ram_we     = 1'b1;
      ram_waddr  = clr_addr_q;
      ram_wdata  = '0;
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == {IDX_W{1'b1}}) begin
        state_d = S_RUN;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
      run_q      <= 1'b0;
      tag_q      <= '0;
      pc_inc_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= ready_d;
      run_q      <= (state_q == S_RUN);
      tag_q      <= r_pc[PC_W-1:IDX_W];
      pc_inc_q   <= r_pc + 1'b1;
    end
  end

  f_btb_lookup_btb_ram #(
    .ADDR_W (IDX_W),
    .DATA_W (ENT_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (r_pc[IDX_W-1:0]),
    .rdata_o (ram_rdata)
  );

  // Lookup result is formed from the RAM read register and the captured PC
  // fields, so both outputs change only on the edge that ends the lookup.
  assign hit          = run_q && ram_rdata[VALID_BIT]
                        && (ram_rdata[TAG_LSB +: TAG_W] == tag_q);
  assign pc_predicted = hit ? ram_rdata[TGT_LSB +: PC_W] : pc_inc_q;
  assign ready        = ready_q;

endmodule

`default_nettype wire
